linebuf_reader: RTL and testbench

// - Read side of the pixel line buffer. The upstream colour-conversion stage fills this buffer

---
 rtl/linebuf_pkg.sv | 21 ++
 rtl/linebuf_align_pipe.sv | 27 ++
 rtl/linebuf_reader.sv | 166 ++++++++++++++++
 tb/tb_linebuf_reader.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/linebuf_pkg.sv
// Shared types and constants for the pixel line-buffer read side.
package linebuf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_BLANK  = 2'd3
  } lb_state_e;

  localparam int PIXEL_W       = 24;
  localparam int RAM_WIDTH_DEF = 10;

  typedef logic [PIXEL_W-1:0] pixel_t;

  // Counter width for a count bound: one spare bit above $clog2.
  function automatic int cnt_w(input int bound);
    return $clog2(bound) + 1;
  endfunction

endpackage

// File: rtl/linebuf_align_pipe.sv
// Delay line that carries read-side markers alongside the buffer RAM latency.
module linebuf_align_pipe #(
  parameter int DEPTH = 3,
  parameter int W     = 3
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] in_i,
  output logic         tap_valid_o,
  output logic [W-1:0] out_o
);

  logic [DEPTH*W-1:0] sh_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      sh_q <= '0;
    end else begin
      sh_q <= {sh_q[(DEPTH-1)*W-1:0], in_i};
    end
  end

  // MSB of the stage before last: the RAM data is valid in this cycle.
  assign tap_valid_o = sh_q[(DEPTH-1)*W-1];
  assign out_o       = sh_q[DEPTH*W-1 -: W];

endmodule

// File: rtl/linebuf_reader.sv
// Read side of the pixel line buffer: waits a fill margin after the frame trigger,
// then streams LINES x PIXELS_PER_LINE pixels with per-line blanking.
//
// state  | meaning
// IDLE   | no frame in progress
// WAIT   | fill margin countdown after starttrigger
// ACTIVE | one buffer read per cycle for the current line
// BLANK  | inter-line gap, no reads
module linebuf_reader
  import linebuf_pkg::*;
#(
  parameter int RAM_WIDTH       = RAM_WIDTH_DEF,
  parameter int PIXELS_PER_LINE = 640,
  parameter int LINES           = 480,
  parameter int H_BLANK         = 160,
  parameter int START_DELAY     = 1280,
  parameter int RAM_LATENCY     = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 starttrigger,
  output logic                 rden,
  output logic [RAM_WIDTH-1:0] rdaddr,
  input  logic [PIXEL_W-1:0]   rddata,
  output logic [PIXEL_W-1:0]   out_data,
  output logic                 out_de,
  output logic                 out_lstart,
  output logic                 out_fstart,
  output logic                 busy,
  output logic                 trig_err
);

  localparam int PIX_W  = cnt_w(PIXELS_PER_LINE);
  localparam int LINE_W = cnt_w(LINES);
  localparam int BLK_W  = cnt_w(H_BLANK);
  localparam int DLY_W  = cnt_w(START_DELAY);

  localparam logic [PIX_W-1:0]  LAST_PIX  = PIX_W'(PIXELS_PER_LINE - 1);
  localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(LINES - 1);
  localparam logic [BLK_W-1:0]  BLK_INIT  = BLK_W'(H_BLANK - 1);
  localparam logic [DLY_W-1:0]  DLY_INIT  = DLY_W'(START_DELAY - 1);

  lb_state_e            state_q;
  logic [PIX_W-1:0]     pix_q;
  logic [LINE_W-1:0]    line_q;
  logic [BLK_W-1:0]     blk_q;
  logic [DLY_W-1:0]     dly_q;
  logic                 rden_q;
  logic [RAM_WIDTH-1:0] rdaddr_q;
  logic                 lstart_q;
  logic                 fstart_q;
  logic                 busy_q;
  logic                 trig_err_q;
  pixel_t               out_data_q;
  pixel_t               out_data_d;

  logic                 tap_valid;
  logic [2:0]           pipe_out;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      pix_q      <= '0;
      line_q     <= '0;
      blk_q      <= '0;
      dly_q      <= '0;
      rden_q     <= 1'b0;
      rdaddr_q   <= '0;
      lstart_q   <= 1'b0;
      fstart_q   <= 1'b0;
      busy_q     <= 1'b0;
      trig_err_q <= 1'b0;
    end else begin
      trig_err_q <= 1'b0;
      if (starttrigger) begin
        // A trigger always (re)starts the frame; while busy it also aborts.
        state_q    <= ST_WAIT;
        busy_q     <= 1'b1;
        dly_q      <= DLY_INIT;
        rden_q     <= 1'b0;
        lstart_q   <= 1'b0;
        fstart_q   <= 1'b0;
        rdaddr_q   <= '0;
        trig_err_q <= busy_q;
      end else begin
        case (state_q)
          ST_IDLE: begin
          end
          ST_WAIT: begin
            if (dly_q == '0) begin
              state_q  <= ST_ACTIVE;
              rden_q   <= 1'b1;
              lstart_q <= 1'b1;
              fstart_q <= 1'b1;
              pix_q    <= '0;
              line_q   <= '0;
              rdaddr_q <= '0;
            end else begin
              dly_q <= dly_q - DLY_W'(1);
            end
          end
          ST_ACTIVE: begin
            rdaddr_q <= rdaddr_q + RAM_WIDTH'(1);
            lstart_q <= 1'b0;
            fstart_q <= 1'b0;
            if (pix_q == LAST_PIX) begin
              rden_q <= 1'b0;
              if (line_q == LAST_LINE) begin
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
              end else begin
                state_q <= ST_BLANK;
                blk_q   <= BLK_INIT;
              end
            end else begin
              pix_q <= pix_q + PIX_W'(1);
            end
          end
          ST_BLANK: begin
            if (blk_q == '0) begin
              state_q  <= ST_ACTIVE;
              rden_q   <= 1'b1;
              lstart_q <= 1'b1;
              pix_q    <= '0;
              line_q   <= line_q + LINE_W'(1);
            end else begin
              blk_q <= blk_q - BLK_W'(1);
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  linebuf_align_pipe #(
    .DEPTH(RAM_LATENCY + 1),
    .W    (3)
  ) u_align (
    .clock      (clock),
    .reset      (reset),
    .in_i       ({rden_q, lstart_q, fstart_q}),
    .tap_valid_o(tap_valid),
    .out_o      (pipe_out)
  );

  always_comb begin
    out_data_d = out_data_q;
    if (tap_valid) out_data_d = rddata;
  end

  always_ff @(posedge clock) begin
    if (reset) out_data_q <= '0;
    else       out_data_q <= out_data_d;
  end

  assign rden       = rden_q;
  assign rdaddr     = rdaddr_q;
  assign busy       = busy_q;
  assign trig_err   = trig_err_q;
  assign out_data   = out_data_q;
  assign out_de     = pipe_out[2];
  assign out_lstart = pipe_out[1];
  assign out_fstart = pipe_out[0];

endmodule

// File: tb/tb_linebuf_reader.sv
// Scoreboard bench for linebuf_reader: several instances (latency sweep and address wrap)
// share one random trigger/reset stream; each has its own frame-schedule reference model.
module tb_linebuf_reader;

  localparam int NI = 5;
  localparam int RL_T  [NI] = '{1, 2, 3, 4, 2};
  localparam int PPL_T [NI] = '{4, 4, 4, 4, 10};
  localparam int LN_T  [NI] = '{2, 2, 2, 2, 1};
  localparam int HB = 3;
  localparam int SD = 5;
  localparam int RW = 3;

  typedef struct {
    int rcyc;
    int addr;
    bit ls;
    bit fs;
  } rd_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic starttrigger = 1'b0;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [23:0] pix_of(input int a);
    logic [7:0] b;
    b = 8'(a);
    return {b ^ 8'hA5, b, ~b};
  endfunction

  task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d cyc=%0d got=%0h exp=%0h", nm, g, cyc, act, exp);
    end
  endtask

  for (genvar g = 0; g < NI; g++) begin : gi
    localparam int RL  = RL_T[g];
    localparam int PPL = PPL_T[g];
    localparam int LN  = LN_T[g];

    logic          rden;
    logic [RW-1:0] rdaddr;
    logic [23:0]   rddata;
    logic [23:0]   out_data;
    logic          out_de, out_lstart, out_fstart, busy, trig_err;
    logic [RW-1:0] a_sh [RL];

    linebuf_reader #(
      .RAM_WIDTH      (RW),
      .PIXELS_PER_LINE(PPL),
      .LINES          (LN),
      .H_BLANK        (HB),
      .START_DELAY    (SD),
      .RAM_LATENCY    (RL)
    ) dut (
      .clock       (clock),
      .reset       (reset),
      .starttrigger(starttrigger),
      .rden        (rden),
      .rdaddr      (rdaddr),
      .rddata      (rddata),
      .out_data    (out_data),
      .out_de      (out_de),
      .out_lstart  (out_lstart),
      .out_fstart  (out_fstart),
      .busy        (busy),
      .trig_err    (trig_err)
    );

    // RAM model: data is a function of the address presented RL cycles earlier.
    always @(posedge clock) begin
      a_sh[0] <= rdaddr;
      for (int i = 1; i < RL; i++) a_sh[i] <= a_sh[i-1];
    end
    assign rddata = pix_of(int'(a_sh[RL-1]));

    initial begin
      rd_t         q[$];
      rd_t         r;
      int          busy_lo, busy_hi, err_cyc, base, ea;
      bit          erd, ede;
      logic [23:0] exp_data;
      busy_lo  = 0;
      busy_hi  = -1;
      err_cyc  = -1;
      exp_data = '0;
      forever begin
        @(posedge clock);
        // Reference model: whole-frame read schedule computed at trigger time.
        if (reset) begin
          q.delete();
          busy_hi  = -1;
          err_cyc  = -1;
          exp_data = '0;
        end else if (starttrigger) begin
          if (cyc >= busy_lo && cyc <= busy_hi) begin
            err_cyc = cyc + 1;
            while (q.size() > 0 && q[$].rcyc > cyc) void'(q.pop_back());
          end
          base = cyc + SD + 1;
          for (int l = 0; l < LN; l++) begin
            for (int p = 0; p < PPL; p++) begin
              r.rcyc = base + l * (PPL + HB) + p;
              r.addr = (l * PPL + p) % (1 << RW);
              r.ls   = (p == 0);
              r.fs   = (p == 0) && (l == 0);
              q.push_back(r);
            end
          end
          busy_lo = cyc + 1;
          busy_hi = base + (LN - 1) * (PPL + HB) + PPL - 1;
        end

        @(negedge clock);
        if (mon_en) begin
          erd = 1'b0;
          ea  = 0;
          foreach (q[i]) begin
            if (q[i].rcyc == cyc) begin
              erd = 1'b1;
              ea  = q[i].addr;
            end
          end
          chk("rden", g, 32'(rden), 32'(erd));
          if (erd) chk("rdaddr", g, 32'(rdaddr), 32'(ea));
          chk("busy", g, 32'(busy), 32'(cyc >= busy_lo && cyc <= busy_hi));
          chk("trig_err", g, 32'(trig_err), 32'(cyc == err_cyc));
          ede = (q.size() > 0) && (q[0].rcyc + RL + 1 == cyc);
          chk("out_de", g, 32'(out_de), 32'(ede));
          if (ede) begin
            exp_data = pix_of(q[0].addr);
            chk("out_lstart", g, 32'(out_lstart), 32'(q[0].ls));
            chk("out_fstart", g, 32'(out_fstart), 32'(q[0].fs));
            void'(q.pop_front());
          end else begin
            chk("out_lstart_idle", g, 32'(out_lstart), 32'd0);
            chk("out_fstart_idle", g, 32'(out_fstart), 32'd0);
          end
          chk("out_data", g, 32'(out_data), 32'(exp_data));
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic pulse();
    starttrigger = 1'b1;
    step(1);
    starttrigger = 1'b0;
  endtask

  initial begin
    int r;
    step(3);
    reset  = 1'b0;
    mon_en = 1'b1;
    step(5);

    // Basic frame
    pulse();
    step(40);

    // Retrigger in line 1 pixel 2 (last pixel for the single-line wrap instance)
    pulse();
    step(14);
    pulse();
    step(40);

    // Reset mid-ACTIVE, then a clean frame
    pulse();
    step(7);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step(5);
    pulse();
    step(40);

    // Retrigger during the fill margin, and back-to-back triggers
    pulse();
    step(3);
    pulse();
    pulse();
    step(40);

    // Random triggers and occasional resets
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 199));
      starttrigger = (r < 5);
      reset        = (r == 199);
      step(1);
    end
    starttrigger = 1'b0;
    reset        = 1'b0;
    step(60);

    // Idle robustness
    step(10000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
